jpegls_byte_packer: RTL and testbench

- Sits directly downstream of JPEGLS_Final and consumes its variable-length bit chunks (dataOut/dataSize/dataReady).
- Packs the chunks MSB-first into a byte stream and applies JPEG-LS marker bit-stuffing after every 0xFF in the entropy-coded segment.
- On endOfDataStream it zero-pads to a byte boundary and appends the EOI marker.
- Output is a valid/ready byte interface toward the file/DMA writer. The encoder cannot stall, so the block buffers internally.

---
 rtl/jpegls_byte_packer.sv | 163 ++++++++++++++++
 tb/tb_jpegls_byte_packer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpegls_byte_packer.sv
// jpegls_byte_packer: packs variable-length encoder chunks MSB-first into a
// byte stream, inserts a 0 bit after every 0xFF of entropy-coded data,
// zero-pads the tail and appends the EOI marker (0xFF 0xD9).
module jpegls_byte_packer #(
   parameter int dataOut_length      = 64,
   parameter int encodedlength_width = 7,
   parameter int HEADER_MARKER_SIZE  = 0,
   parameter int ACC_DEPTH           = 512,
   parameter int cnt_width           = 10
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           dataReady,
   input  logic [dataOut_length-1:0]      dataOut,
   input  logic [encodedlength_width-1:0] dataSize,
   input  logic                           endOfDataStream,
   output logic [7:0]                     byte_out,
   output logic                           byte_valid,
   input  logic                           byte_ready,
   output logic                           done,
   output logic                           overflow
);
   localparam int HDR_BYTES = HEADER_MARKER_SIZE / 8;
   localparam int HDR_W     = (HDR_BYTES < 1) ? 1 : $clog2(HDR_BYTES + 1);

   typedef enum logic [2:0] {RUN, FLUSH, EOI_FF, EOI_D9, DONE} state_t;

   state_t                    state;
   // Bit accumulator: the oldest bit sits at the MSB, bits below count are zero.
   logic [ACC_DEPTH-1:0]      acc;
   logic [cnt_width-1:0]      count;
   logic                      stuff_pending;
   logic                      eos_latched;
   logic [HDR_W-1:0]          hdr_cnt;

   logic                      load_en;
   logic                      hdr_done;
   logic                      byte_avail;
   logic                      pop_en;
   logic [7:0]                head_byte;
   logic [cnt_width-1:0]      consumed;
   logic [cnt_width-1:0]      fill_after_pop;
   logic [cnt_width:0]        fill_total;
   logic                      append_req;
   logic                      append_fit;
   logic [dataOut_length-1:0] chunk_masked;
   logic [ACC_DEPTH-1:0]      acc_popped;
   logic [ACC_DEPTH-1:0]      chunk_placed;
   logic [ACC_DEPTH-1:0]      acc_next;
   logic                      flush_go;

   // Pop/append datapath: next byte candidate, fill arithmetic and the shifted accumulator
   always_comb begin
      load_en        = !byte_valid || byte_ready;
      hdr_done       = (hdr_cnt == HDR_W'(HDR_BYTES));
      byte_avail     = stuff_pending ? (count >= cnt_width'(7)) : (count >= cnt_width'(8));
      // A stuffed byte carries only 7 stream bits behind a forced 0 MSB.
      head_byte      = stuff_pending ? {1'b0, acc[ACC_DEPTH-1 -: 7]} : acc[ACC_DEPTH-1 -: 8];
      pop_en         = (state == RUN) && load_en && byte_avail;
      consumed       = '0;
      if (pop_en)
         consumed = stuff_pending ? cnt_width'(7) : cnt_width'(8);
      fill_after_pop = count - consumed;
      append_req     = (state == RUN) && dataReady && (dataSize != '0);
      fill_total     = {1'b0, fill_after_pop} + (cnt_width+1)'(dataSize);
      append_fit     = (fill_total <= (cnt_width+1)'(ACC_DEPTH));
      // Clear the don't-care bits below the valid chunk bits.
      chunk_masked   = dataOut & ~({dataOut_length{1'b1}} >> dataSize);
      acc_popped     = acc << consumed;
      chunk_placed   = {chunk_masked, {(ACC_DEPTH-dataOut_length){1'b0}}} >> fill_after_pop;
      acc_next       = acc_popped;
      if (append_req && append_fit)
         acc_next = acc_popped | chunk_placed;
      // Leave RUN only once no whole byte remains and no late chunk is arriving.
      flush_go       = eos_latched && !byte_avail && !append_req;
   end

   // Accumulator, output byte register and the RUN/FLUSH/EOI state machine
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         acc           <= '0;
         count         <= '0;
         stuff_pending <= 1'b0;
         eos_latched   <= 1'b0;
         hdr_cnt       <= '0;
         byte_out      <= 8'h00;
         byte_valid    <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (append_req && !append_fit)
            overflow <= 1'b1;
         case (state)
            RUN: begin
               acc <= acc_next;
               if (append_req && append_fit)
                  count <= fill_total[cnt_width-1:0];
               else
                  count <= fill_after_pop;
               if (endOfDataStream)
                  eos_latched <= 1'b1;
               if (load_en) begin
                  if (byte_avail) begin
                     byte_out   <= head_byte;
                     byte_valid <= 1'b1;
                     if (stuff_pending)
                        stuff_pending <= 1'b0;
                     else if (head_byte == 8'hFF && hdr_done)
                        stuff_pending <= 1'b1;
                     if (!hdr_done)
                        hdr_cnt <= hdr_cnt + 1'b1;
                  end else begin
                     byte_valid <= 1'b0;
                  end
               end
               if (flush_go)
                  state <= FLUSH;
            end
            FLUSH: begin
               if (load_en) begin
                  // Remaining bits are already zero-padded, so this byte is never 0xFF.
                  if (count != '0 || stuff_pending) begin
                     byte_out   <= head_byte;
                     byte_valid <= 1'b1;
                  end else begin
                     byte_valid <= 1'b0;
                  end
                  acc           <= '0;
                  count         <= '0;
                  stuff_pending <= 1'b0;
                  state         <= EOI_FF;
               end
            end
            EOI_FF: begin
               if (load_en) begin
                  byte_out   <= 8'hFF;
                  byte_valid <= 1'b1;
                  state      <= EOI_D9;
               end
            end
            EOI_D9: begin
               if (load_en) begin
                  // 0xD9 already on the output and accepted now: the stream is complete.
                  if (byte_valid && byte_out == 8'hD9) begin
                     byte_valid <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else begin
                     byte_out   <= 8'hD9;
                     byte_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               byte_valid <= 1'b0;
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_jpegls_byte_packer.sv
// Bench for jpegls_byte_packer: two instances (no header, 16-bit header) share
// stimulus; each has its own expected-byte queue checked on every accepted byte.
module tb_jpegls_byte_packer;
   logic        clk;
   logic        reset;
   logic        dataReady;
   logic [63:0] dataOut;
   logic [6:0]  dataSize;
   logic        endOfDataStream;
   logic        byte_ready;
   logic [7:0]  bo [2];
   logic        bv [2];
   logic        dn [2];
   logic        ov [2];

   int total = 0;
   int bad   = 0;
   int done_cnt [2];
   logic [7:0] exp_q0 [$];
   logic [7:0] exp_q1 [$];
   logic       rand_ready = 1'b0;
   logic       prev_v [2];
   logic [7:0] prev_b [2];
   logic       prev_r;

   typedef struct {
      string            name;
      int               n_chunks;
      logic [2:0][63:0] data;
      logic [2:0][6:0]  size;
      int               n0;
      logic [47:0]      exp0;
      int               n1;
      logic [47:0]      exp1;
   } vec_t;
   vec_t vecs [4];

   jpegls_byte_packer #(.HEADER_MARKER_SIZE(0)) dut0 (
      .clk(clk), .reset(reset), .dataReady(dataReady), .dataOut(dataOut),
      .dataSize(dataSize), .endOfDataStream(endOfDataStream),
      .byte_out(bo[0]), .byte_valid(bv[0]), .byte_ready(byte_ready),
      .done(dn[0]), .overflow(ov[0]));

   jpegls_byte_packer #(.HEADER_MARKER_SIZE(16)) dut1 (
      .clk(clk), .reset(reset), .dataReady(dataReady), .dataOut(dataOut),
      .dataSize(dataSize), .endOfDataStream(endOfDataStream),
      .byte_out(bo[1]), .byte_valid(bv[1]), .byte_ready(byte_ready),
      .done(dn[1]), .overflow(ov[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic check_pop(input int i, input logic [7:0] got);
      logic [7:0] want;
      logic       empty;
      empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      total++;
      if (empty) begin
         bad++;
         $display("FAIL byte_dut%0d: got %02h, required no byte", i, got);
      end else begin
         if (i == 0) want = exp_q0.pop_front();
         else        want = exp_q1.pop_front();
         if (got !== want) begin
            bad++;
            $display("FAIL byte_dut%0d: got %02h, required %02h", i, got, want);
         end else begin
            $display("dut%0d byte %02h accepted as expected", i, got);
         end
      end
   endtask

   // Output monitor: scoreboard pop on accept, hold rule, done pulse count
   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            if (prev_v[i] && !prev_r) begin
               total++;
               if (!bv[i] || bo[i] !== prev_b[i]) begin
                  bad++;
                  $display("FAIL hold_dut%0d: valid=%0b byte=%02h, required valid=1 byte=%02h",
                           i, bv[i], bo[i], prev_b[i]);
               end
            end
            if (bv[i] && byte_ready)
               check_pop(i, bo[i]);
            if (dn[i])
               done_cnt[i]++;
         end
      end
      for (int i = 0; i < 2; i++) begin
         prev_v[i] = reset ? 1'b0 : bv[i];
         prev_b[i] = bo[i];
      end
      prev_r = byte_ready;
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready)
         byte_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle_inputs();
      dataReady       = 1'b0;
      dataOut         = '0;
      dataSize        = '0;
      endOfDataStream = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_valid%0d", i), 64'(bv[i]), 64'd0);
         chk($sformatf("reset_byte%0d", i), 64'(bo[i]), 64'd0);
         chk($sformatf("reset_done%0d", i), 64'(dn[i]), 64'd0);
         chk($sformatf("reset_ovf%0d", i), 64'(ov[i]), 64'd0);
      end
   endtask

   task automatic finish_stream(input string name);
      int cycles;
      rand_ready = 1'b1;
      cycles = 0;
      while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1) && cycles < 400) begin
         step();
         cycles++;
      end
      total++;
      if (cycles >= 400) begin
         bad++;
         $display("FAIL %s_timeout: done0=%0d done1=%0d, required both done", name, done_cnt[0], done_cnt[1]);
      end
      repeat (4) step();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_done_pulses%0d", name, i), 64'(done_cnt[i]), 64'd1);
         chk($sformatf("%s_valid_after%0d", name, i), 64'(bv[i]), 64'd0);
      end
      chk({name, "_left0"}, 64'(exp_q0.size()), 64'd0);
      chk({name, "_left1"}, 64'(exp_q1.size()), 64'd0);
      $display("stream %s complete", name);
   endtask

   task automatic set_vec(input int idx, input string name, input int n,
                          input logic [63:0] d0, input logic [6:0] s0,
                          input logic [63:0] d1, input logic [6:0] s1,
                          input int n0, input logic [47:0] e0,
                          input int n1, input logic [47:0] e1);
      vecs[idx].name     = name;
      vecs[idx].n_chunks = n;
      vecs[idx].data[0]  = d0;
      vecs[idx].size[0]  = s0;
      vecs[idx].data[1]  = d1;
      vecs[idx].size[1]  = s1;
      vecs[idx].data[2]  = '0;
      vecs[idx].size[2]  = '0;
      vecs[idx].n0       = n0;
      vecs[idx].exp0     = e0;
      vecs[idx].n1       = n1;
      vecs[idx].exp1     = e1;
   endtask

   task automatic push_exp(input int n0, input logic [47:0] e0, input int n1, input logic [47:0] e1);
      for (int j = 0; j < n0; j++) exp_q0.push_back(e0[47-8*j -: 8]);
      for (int j = 0; j < n1; j++) exp_q1.push_back(e1[47-8*j -: 8]);
   endtask

   task automatic run_case(input int idx);
      vec_t v;
      v = vecs[idx];
      do_reset();
      rand_ready = 1'b1;
      push_exp(v.n0, v.exp0, v.n1, v.exp1);
      for (int c = 0; c < v.n_chunks; c++) begin
         dataReady       = 1'b1;
         dataOut         = v.data[c];
         dataSize        = v.size[c];
         endOfDataStream = (c == v.n_chunks - 1);
         step();
      end
      idle_inputs();
      finish_stream(v.name);
   endtask

   initial begin
      reset      = 1'b1;
      byte_ready = 1'b0;
      idle_inputs();

      // Low bits below dataSize carry garbage to exercise masking.
      set_vec(0, "basic", 2, 64'hBFFF_FFFF_FFFF_FFFF, 7'd3, 64'h9FFF_FFFF_FFFF_FFFF, 7'd5,
              3, 48'hB3FFD9_000000, 3, 48'hB3FFD9_000000);
      set_vec(1, "ones16", 1, 64'hFFFF_0000_0000_1234, 7'd16, 64'h0, 7'd0,
              5, 48'hFF7F80FFD9_00, 4, 48'hFFFFFFD9_0000);
      set_vec(2, "ff_end", 1, 64'hFF12_3456_789A_BCDE, 7'd8, 64'h0, 7'd0,
              4, 48'hFF00FFD9_0000, 3, 48'hFFFFD9_000000);
      set_vec(3, "header", 2, 64'hFFD8_0000_0000_0000, 7'd16, 64'hFF00_0000_0000_0000, 7'd8,
              6, 48'hFF6C7F80FFD9, 6, 48'hFFD8FF00FFD9);

      for (int t = 0; t < 4; t++)
         run_case(t);

      // Backpressure: 64-bit chunks every cycle while the sink stalls.
      do_reset();
      rand_ready = 1'b0;
      byte_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         logic [63:0] d;
         for (int j = 0; j < 8; j++)
            d[63-8*j -: 8] = 8'(k * 8 + j);
         if (k < 8) begin
            for (int j = 0; j < 8; j++) begin
               exp_q0.push_back(d[63-8*j -: 8]);
               exp_q1.push_back(d[63-8*j -: 8]);
            end
         end
         dataReady = 1'b1;
         dataOut   = d;
         dataSize  = 7'd64;
         step();
         chk($sformatf("bp_ovf0_k%0d", k), 64'(ov[0]), (k >= 8) ? 64'd1 : 64'd0);
         chk($sformatf("bp_ovf1_k%0d", k), 64'(ov[1]), (k >= 8) ? 64'd1 : 64'd0);
      end
      idle_inputs();
      endOfDataStream = 1'b1;
      step();
      endOfDataStream = 1'b0;
      push_exp(2, 48'hFFD9_00000000, 2, 48'hFFD9_00000000);
      chk("bp_held_valid", 64'(bv[0]), 64'd1);
      chk("bp_held_byte", 64'(bo[0]), 64'h00);
      finish_stream("backpressure");
      chk("bp_ovf_sticky", 64'(ov[0]), 64'd1);

      // Reset mid-stream with 12 bits in the accumulator.
      do_reset();
      rand_ready = 1'b0;
      byte_ready = 1'b0;
      dataReady  = 1'b1;
      dataOut    = 64'hABC0_0000_0000_0000;
      dataSize   = 7'd12;
      step();
      idle_inputs();
      chk("latency_no_byte_yet", 64'(bv[0]), 64'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_valid", 64'(bv[0]), 64'd0);
      chk("midrst_ovf", 64'(ov[0]), 64'd0);
      step();
      chk("midrst_acc_cleared", 64'(bv[0]), 64'd0);
      push_exp(3, 48'hA5FFD9_000000, 3, 48'hA5FFD9_000000);
      rand_ready = 1'b1;
      dataReady       = 1'b1;
      dataOut         = 64'hA5FF_FFFF_0000_0000;
      dataSize        = 7'd8;
      endOfDataStream = 1'b1;
      step();
      idle_inputs();
      finish_stream("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
